// File: rtl/riscv_config_pkg.sv
// Core-wide configuration constants.
// Shared by fetch and the trap logic.
package riscv_config_pkg;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int DEFAULT_FETCH_QUEUE_DEPTH = 4;
  localparam int DEFAULT_FETCH_MAX_OUTSTANDING = 2;

  localparam logic [3:0] CAUSE_MISALIGNED_FETCH = 4'd0;
  localparam logic [3:0] CAUSE_FETCH_ACCESS = 4'd1;

  localparam logic [31:0] NOP_INSTRUCTION = 32'h0000_0013;

endpackage

// File: rtl/riscv_core_pkg.sv
// Inter-stage bundles for the core pipeline.
// Fetch-queue entry carried from fetch to decode.
package riscv_core_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc_valid;
    logic [3:0]  exc_cause;
  } fetch_entry_t;

  function automatic logic [31:0] pc_next(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_queue_fifo.sv
// Fetch queue: FIFO of fetch entries with a
// one-cycle flush-and-load port and count output.
module fetch_queue_fifo
  import riscv_config_pkg::*;
  import riscv_core_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          flush_i,
  input  logic          load_i,
  input  fetch_entry_t  load_data_i,
  input  logic          push_i,
  input  fetch_entry_t  push_data_i,
  input  logic          pop_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o
);

  localparam fetch_entry_t EMPTY_ENTRY = '{
    pc:        32'h0,
    instr:     NOP_INSTRUCTION,
    exc_valid: 1'b0,
    exc_cause: 4'd0
  };

  fetch_entry_t  mem_q [DEPTH];
  fetch_entry_t  mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d;
  logic [AW-1:0] wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    mem_d = mem_q;
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = AW'(load_i);
      cnt_d = CW'(load_i);
      if (load_i) begin
        mem_d[0] = load_data_i;
      end
    end else begin
      if (push_i) begin
        mem_d[wr_q] = push_data_i;
        wr_d = wr_q + AW'(1);
      end
      if (pop_i) begin
        rd_d = rd_q + AW'(1);
      end
      cnt_d = cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
    end
  end

  // Payload needs no reset: it is only visible when cnt_q != 0.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head_o  = (cnt_q != '0) ? mem_q[rd_q] : EMPTY_ENTRY;
  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Decoupled instruction prefetcher: in-order requests,
// counted squashing on redirect, queued fetch exceptions.
module fetch_prefetch_unit
  import riscv_config_pkg::*;
  import riscv_core_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter int QUEUE_DEPTH = DEFAULT_FETCH_QUEUE_DEPTH,
  parameter int MAX_OUTSTANDING = DEFAULT_FETCH_MAX_OUTSTANDING,
  localparam int CW = $clog2(QUEUE_DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          redirect_en_i,
  input  logic [31:0]   redirect_target_i,
  output logic          instr_req_valid_o,
  input  logic          instr_req_ready_i,
  output logic [31:0]   instr_req_addr_o,
  input  logic          instr_rsp_valid_i,
  output logic          instr_rsp_ready_o,
  input  logic [31:0]   instr_rsp_data_i,
  input  logic          instr_rsp_error_i,
  output logic          fetch_valid_o,
  input  logic          fetch_ready_i,
  output logic [31:0]   fetch_instr_o,
  output logic [31:0]   fetch_pc_o,
  output logic          fetch_exc_valid_o,
  output logic [3:0]    fetch_exc_cause_o,
  output logic [CW-1:0] occupancy_o,
  output logic [31:0]   discard_count_o
);

  localparam logic [CW-1:0] MAX_O = CW'(MAX_OUTSTANDING);
  localparam logic [CW:0]   QD    = (CW + 1)'(QUEUE_DEPTH);

  logic [31:0]   req_pc_q, req_pc_d;
  logic [31:0]   rsp_pc_q, rsp_pc_d;
  logic [31:0]   disc_cnt_q, disc_cnt_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] discard_q, discard_d;
  logic          halted_q, halted_d;

  logic [CW-1:0] q_count;
  fetch_entry_t  head, push_entry, load_entry;
  logic          req_fire, rsp_fire, rsp_drop;
  logic          push, pop, misaligned;
  logic [CW:0]   reserved;

  assign misaligned = redirect_target_i[1:0] != 2'b00;
  // In-flight requests reserve queue slots, even doomed ones.
  assign reserved = {1'b0, out_q} + {1'b0, q_count};

  assign instr_req_valid_o = rst_ni && !halted_q && !redirect_en_i
                          && (out_q < MAX_O) && (reserved < QD);
  assign instr_req_addr_o  = {req_pc_q[31:2], 2'b00};
  assign instr_rsp_ready_o = 1'b1;

  assign req_fire = instr_req_valid_o && instr_req_ready_i;
  assign rsp_fire = instr_rsp_valid_i;
  assign rsp_drop = rsp_fire && (redirect_en_i || discard_q != '0);
  assign push     = rsp_fire && !rsp_drop;
  assign pop      = fetch_valid_o && fetch_ready_i && !redirect_en_i;

  always_comb begin
    push_entry.pc        = rsp_pc_q;
    push_entry.instr     = instr_rsp_error_i ? NOP_INSTRUCTION
                                             : instr_rsp_data_i;
    push_entry.exc_valid = instr_rsp_error_i;
    push_entry.exc_cause = instr_rsp_error_i ? CAUSE_FETCH_ACCESS : 4'd0;

    load_entry.pc        = redirect_target_i;
    load_entry.instr     = NOP_INSTRUCTION;
    load_entry.exc_valid = 1'b1;
    load_entry.exc_cause = CAUSE_MISALIGNED_FETCH;
  end

  always_comb begin
    out_d      = out_q + CW'(req_fire) - CW'(rsp_fire);
    req_pc_d   = req_pc_q;
    rsp_pc_d   = rsp_pc_q;
    discard_d  = discard_q;
    halted_d   = halted_q;
    disc_cnt_d = disc_cnt_q;
    if (req_fire) begin
      req_pc_d = pc_next(req_pc_q);
    end
    if (rsp_drop && disc_cnt_q != '1) begin
      disc_cnt_d = disc_cnt_q + 32'd1;
    end
    if (redirect_en_i) begin
      discard_d = out_q - CW'(rsp_fire);
      req_pc_d  = redirect_target_i;
      rsp_pc_d  = redirect_target_i;
      halted_d  = misaligned;
    end else if (rsp_fire) begin
      if (discard_q != '0) begin
        discard_d = discard_q - CW'(1);
      end else begin
        rsp_pc_d = pc_next(rsp_pc_q);
        if (instr_rsp_error_i) begin
          halted_d  = 1'b1;
          discard_d = out_d;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_pc_q   <= RESET_VECTOR;
      rsp_pc_q   <= RESET_VECTOR;
      disc_cnt_q <= '0;
      out_q      <= '0;
      discard_q  <= '0;
      halted_q   <= 1'b0;
    end else begin
      req_pc_q   <= req_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      disc_cnt_q <= disc_cnt_d;
      out_q      <= out_d;
      discard_q  <= discard_d;
      halted_q   <= halted_d;
    end
  end

  fetch_queue_fifo #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (redirect_en_i),
    .load_i     (redirect_en_i && misaligned),
    .load_data_i(load_entry),
    .push_i     (push),
    .push_data_i(push_entry),
    .pop_i      (pop),
    .head_o     (head),
    .count_o    (q_count)
  );

  assign fetch_valid_o     = q_count != '0;
  assign fetch_instr_o     = head.instr;
  assign fetch_pc_o        = head.pc;
  assign fetch_exc_valid_o = head.exc_valid;
  assign fetch_exc_cause_o = head.exc_cause;
  assign occupancy_o       = q_count;
  assign discard_count_o   = disc_cnt_q;

  rsp_without_req_a: assert property (
    @(posedge clk_i) disable iff (!rst_ni)
    instr_rsp_valid_i |-> out_q != '0
  );

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Directed bench for fetch_prefetch_unit with an
// in-order memory model of one-cycle latency.
module tb_fetch_prefetch_unit;
  import riscv_config_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_en = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        req_valid;
  logic        req_ready = 1'b1;
  logic [31:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic        rsp_ready;
  logic [31:0] rsp_data = '0;
  logic        rsp_err = 1'b0;
  logic        fv;
  logic        fetch_ready = 1'b0;
  logic [31:0] f_instr, f_pc;
  logic        f_exc;
  logic [3:0]  f_cause;
  logic [2:0]  occ;
  logic [31:0] disc;

  fetch_prefetch_unit dut (
    .clk_i            (clk),
    .rst_ni           (rst_n),
    .redirect_en_i    (redirect_en),
    .redirect_target_i(redirect_target),
    .instr_req_valid_o(req_valid),
    .instr_req_ready_i(req_ready),
    .instr_req_addr_o (req_addr),
    .instr_rsp_valid_i(rsp_valid),
    .instr_rsp_ready_o(rsp_ready),
    .instr_rsp_data_i (rsp_data),
    .instr_rsp_error_i(rsp_err),
    .fetch_valid_o    (fv),
    .fetch_ready_i    (fetch_ready),
    .fetch_instr_o    (f_instr),
    .fetch_pc_o       (f_pc),
    .fetch_exc_valid_o(f_exc),
    .fetch_exc_cause_o(f_cause),
    .occupancy_o      (occ),
    .discard_count_o  (disc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        exc;
    logic [3:0]  cause;
  } ent_t;

  typedef struct {
    logic        redir;
    logic [31:0] tgt;
    logic        fr;
    logic        req_v;
    logic [31:0] addr;
    logic        fv;
    logic [31:0] pc;
    logic [2:0]  occ;
  } vec_t;

  int n_chk = 0;
  int n_fail = 0;

  logic [31:0] mq[$];
  ent_t        log_q[$];
  logic        mem_hold = 1'b0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;

  logic        s_req_v, s_fv, s_exc, s_pop;
  logic [31:0] s_addr, s_pc, s_instr;
  logic [3:0]  s_cause;
  logic [2:0]  s_occ;

  function automatic logic [31:0] mdata(input logic [31:0] a);
    return a + 32'h5500_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic tick(input logic redir, input logic [31:0] tgt,
                      input logic fr);
    redirect_en = redir;
    redirect_target = tgt;
    fetch_ready = fr;
    if (!mem_hold && mq.size() > 0) begin
      rsp_valid = 1'b1;
      rsp_data  = mdata(mq[0]);
      rsp_err   = err_en && (mq[0] == err_addr);
    end else begin
      rsp_valid = 1'b0;
      rsp_data  = '0;
      rsp_err   = 1'b0;
    end
    #1;
    s_req_v = req_valid && req_ready;
    s_addr  = req_addr;
    s_fv    = fv;
    s_pc    = f_pc;
    s_instr = f_instr;
    s_exc   = f_exc;
    s_cause = f_cause;
    s_occ   = occ;
    s_pop   = fv && fr && !redir;
    @(posedge clk);
    if (s_req_v) mq.push_back(s_addr);
    if (rsp_valid) void'(mq.pop_front());
    if (s_pop) log_q.push_back('{s_pc, s_instr, s_exc, s_cause});
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    redirect_en = 1'b0;
    fetch_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err = 1'b0;
    mem_hold = 1'b0;
    err_en = 1'b0;
    #1;
    chk("rst_req_valid", req_valid, 0);
    chk("rst_fetch_valid", fv, 0);
    chk("rst_exc_valid", f_exc, 0);
    chk("rst_instr", f_instr, NOP_INSTRUCTION);
    chk("rst_pc", f_pc, 0);
    chk("rst_occ", occ, 0);
    chk("rst_discard", disc, 0);
    @(posedge clk);
    @(negedge clk);
    mq.delete();
    log_q.delete();
    rst_n = 1'b1;
  endtask

  vec_t vec [10];

  initial begin
    vec[0] = '{0, 32'h0,  1, 1, 32'h00, 0, 32'h00, 3'd0};
    vec[1] = '{0, 32'h0,  1, 1, 32'h04, 0, 32'h00, 3'd0};
    vec[2] = '{0, 32'h0,  1, 1, 32'h08, 1, 32'h00, 3'd1};
    vec[3] = '{0, 32'h0,  1, 1, 32'h0C, 1, 32'h04, 3'd1};
    vec[4] = '{0, 32'h0,  1, 1, 32'h10, 1, 32'h08, 3'd1};
    vec[5] = '{0, 32'h0,  1, 1, 32'h14, 1, 32'h0C, 3'd1};
    vec[6] = '{1, 32'h40, 1, 0, 32'h18, 1, 32'h10, 3'd1};
    vec[7] = '{0, 32'h0,  1, 1, 32'h40, 0, 32'h00, 3'd0};
    vec[8] = '{0, 32'h0,  1, 1, 32'h44, 0, 32'h00, 3'd0};
    vec[9] = '{0, 32'h0,  1, 1, 32'h48, 1, 32'h40, 3'd1};

    @(negedge clk);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      tick(vec[i].redir, vec[i].tgt, vec[i].fr);
      chk($sformatf("t1_req_v[%0d]", i), s_req_v, vec[i].req_v);
      chk($sformatf("t1_addr[%0d]", i), s_addr, vec[i].addr);
      chk($sformatf("t1_fv[%0d]", i), s_fv, vec[i].fv);
      chk($sformatf("t1_pc[%0d]", i), s_pc, vec[i].pc);
      chk($sformatf("t1_instr[%0d]", i), s_instr,
          vec[i].fv ? mdata(vec[i].pc) : NOP_INSTRUCTION);
      chk($sformatf("t1_occ[%0d]", i), s_occ, vec[i].occ);
    end
    chk("t1_discard", disc, 1);

    // Backpressure: queue fills by reservation.
    do_reset();
    for (int i = 0; i < 7; i++) tick(0, 0, 0);
    chk("t2_occ_full", s_occ, 4);
    chk("t2_req_blocked", s_req_v, 0);
    chk("t2_head_stable", s_pc, 0);
    tick(0, 0, 1);
    chk("t2_pop_fv", s_fv, 1);
    chk("t2_pop_req", s_req_v, 0);
    tick(0, 0, 0);
    chk("t2_reissue", s_req_v, 1);
    chk("t2_reissue_addr", s_addr, 32'h10);
    chk("t2_occ_after", s_occ, 3);

    // Redirect with two requests in flight.
    do_reset();
    mem_hold = 1'b1;
    tick(0, 0, 1);
    tick(0, 0, 1);
    tick(0, 0, 1);
    chk("t3_limit", s_req_v, 0);
    tick(1, 32'h100, 1);
    mem_hold = 1'b0;
    for (int i = 0; i < 8; i++) tick(0, 0, 1);
    chk("t3_discard", disc, 2);
    chk("t3_log_nonempty", log_q.size() > 0, 1);
    if (log_q.size() > 0) begin
      chk("t3_first_pc", log_q[0].pc, 32'h100);
      chk("t3_first_instr", log_q[0].instr, mdata(32'h100));
    end

    // Misaligned redirect.
    do_reset();
    tick(1, 32'h102, 0);
    chk("t4_no_req_redir", s_req_v, 0);
    tick(0, 0, 0);
    chk("t4_fv", s_fv, 1);
    chk("t4_exc", s_exc, 1);
    chk("t4_cause", s_cause, CAUSE_MISALIGNED_FETCH);
    chk("t4_pc", s_pc, 32'h102);
    chk("t4_instr", s_instr, NOP_INSTRUCTION);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 0);
      chk($sformatf("t4_halt[%0d]", i), s_req_v, 0);
    end
    tick(1, 32'h200, 0);
    tick(0, 0, 0);
    chk("t4_resume", s_req_v, 1);
    chk("t4_resume_addr", s_addr, 32'h200);
    chk("t4_flushed", s_fv, 0);

    // Access fault on the second response.
    do_reset();
    err_en = 1'b1;
    err_addr = 32'h4;
    for (int i = 0; i < 3; i++) tick(0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      tick(0, 0, 1);
      chk($sformatf("t5_halt[%0d]", i), s_req_v, 0);
    end
    chk("t5_empty", s_fv, 0);
    chk("t5_discard", disc, 1);
    chk("t5_log_n", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("t5_e0_pc", log_q[0].pc, 32'h0);
      chk("t5_e0_instr", log_q[0].instr, mdata(32'h0));
      chk("t5_e0_exc", log_q[0].exc, 0);
      chk("t5_e1_pc", log_q[1].pc, 32'h4);
      chk("t5_e1_exc", log_q[1].exc, 1);
      chk("t5_e1_cause", log_q[1].cause, CAUSE_FETCH_ACCESS);
      chk("t5_e1_instr", log_q[1].instr, NOP_INSTRUCTION);
    end
    err_en = 1'b0;

    // Redirect colliding with response fire and decode pop.
    do_reset();
    tick(0, 0, 1);
    tick(0, 0, 1);
    tick(1, 32'h300, 1);
    chk("t6_head_pc", s_pc, 32'h0);
    chk("t6_no_req", s_req_v, 0);
    tick(0, 0, 0);
    chk("t6_empty", s_fv, 0);
    chk("t6_occ", s_occ, 0);
    chk("t6_req", s_req_v, 1);
    chk("t6_addr", s_addr, 32'h300);
    chk("t6_discard", disc, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
